// File: rtl/patgen_pkg.sv
// Shared state type and pattern constants for the 128-bit pattern generator.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [127:0] PAT_INIT = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
  localparam logic [127:0] PAT_INC  = 128'h0000_0004_0000_0004_0000_0004_0000_0004;

  // Full-width add: a lane overflow carries into the next lane up.
  function automatic logic [127:0] pat_next(input logic [127:0] cur);
    return cur + PAT_INC;
  endfunction

endpackage

// File: rtl/pattern_gen_128b_if.sv
// Valid/ready word stream carried from the pattern generator to its consumer.
interface pattern_gen_128b_if;

  logic [127:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/patgen_seq.sv
// Sequence register: holds the next word to present and steps it by PAT_INC.
module patgen_seq
  import patgen_pkg::*;
#(
  parameter logic [127:0] INIT_VAL = PAT_INIT
) (
  input  logic         clk_usr,
  input  logic         rst_n,
  input  logic         adv,
  output logic [127:0] word
);

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      word <= INIT_VAL;
    end else if (adv) begin
      word <= pat_next(word);
    end
  end

endmodule

// File: rtl/pattern_gen_128b.sv
// 128-bit incrementing pattern generator with bursts, gaps and stop control.
// Optional bit-0 error injection is built only when PATGEN_ERR_INJ_EN is defined.
module pattern_gen_128b
  import patgen_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 32
) (
  input  logic                 clk_usr,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_W-1:0]     burst_len,
  input  logic [GAP_W-1:0]     gap_len,
  input  logic                 inj_err,
  pattern_gen_128b_if.master   tx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     word_cnt
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   left_q, left_d;
  logic               cont_q, cont_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic               stop_q, stop_d;
  logic               valid_d, done_d, load;
  logic               accept;
  logic [127:0]       seq_word;
  logic [127:0]       flip;

  assign accept = tx.tx_valid & tx.tx_ready;

  // The sequence steps when a word is loaded for presentation; every presented
  // word is eventually accepted, so this equals one step per accept.
  patgen_seq u_seq (
    .clk_usr (clk_usr),
    .rst_n   (rst_n),
    .adv     (load),
    .word    (seq_word)
  );

`ifdef PATGEN_ERR_INJ_EN
  logic inj_q;

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= 1'b0;
    end else if (load) begin
      inj_q <= 1'b0;
    end else if (inj_err) begin
      inj_q <= 1'b1;
    end
  end

  assign flip = {127'd0, inj_q | inj_err};
`else
  logic unused_inj;
  assign unused_inj = inj_err;
  assign flip       = '0;
`endif

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    cont_d  = cont_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    stop_d  = stop_q;
    valid_d = tx.tx_valid;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start && !stop) begin
          state_d = RUN;
          valid_d = 1'b1;
          load    = 1'b1;
          left_d  = burst_len;
          cont_d  = (burst_len == '0);
          gap_d   = gap_len;
        end
      end
      RUN: begin
        stop_d = stop_q | stop;
        if (accept) begin
          if (!cont_q) begin
            left_d = left_q - LEN_W'(1);
          end
          if ((!cont_q && left_q == LEN_W'(1)) || stop_q || stop) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else if (gap_q != '0) begin
            state_d = GAP;
            valid_d = 1'b0;
            gcnt_d  = gap_q;
          end else begin
            valid_d = 1'b1;
            load    = 1'b1;
          end
        end
      end
      GAP: begin
        // Nothing is on the bus here, so a stop can end the run immediately.
        if (stop_q || stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end else if (gcnt_q == GAP_W'(1)) begin
          state_d = RUN;
          valid_d = 1'b1;
          load    = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      left_q  <= '0;
      cont_q  <= 1'b0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      cont_q  <= cont_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      stop_q  <= stop_d;
    end
  end

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= PAT_INIT;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_cnt    <= '0;
    end else begin
      tx.tx_valid <= valid_d;
      busy        <= (state_d != IDLE);
      done        <= done_d;
      if (load) begin
        tx.tx_data <= seq_word ^ flip;
      end
      if (accept) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen_128b.sv
// Self-checking bench for pattern_gen_128b: directed steps plus randomized runs
// against an arithmetic model (word k = init + k * increment).
module tb_pattern_gen_128b;

  localparam int LEN_W = 16;
  localparam int GAP_W = 8;
  localparam int CNT_W = 32;

  localparam logic [127:0] EXP_INIT   = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
  localparam logic [127:0] EXP_INC    = 128'h0000_0004_0000_0004_0000_0004_0000_0004;
  localparam logic [127:0] CARRY_INIT = 128'h0000_0004_0000_0003_0000_0002_FFFF_FFFD;
  localparam logic [127:0] CARRY_NEXT = 128'h0000_0008_0000_0007_0000_0007_0000_0001;

  logic              clk_usr;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [LEN_W-1:0]  burst_len;
  logic [GAP_W-1:0]  gap_len;
  logic              inj_err;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_cnt;
  logic              adv_s;
  logic [127:0]      carry_word;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  logic flip_exp;

  pattern_gen_128b_if tx_if ();

  pattern_gen_128b #(
    .LEN_W (LEN_W),
    .GAP_W (GAP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_usr   (clk_usr),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .gap_len   (gap_len),
    .inj_err   (inj_err),
    .tx        (tx_if),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
  );

  // Separate sequence instance seeded near a lane boundary to exercise carries.
  patgen_seq #(
    .INIT_VAL (CARRY_INIT)
  ) u_carry (
    .clk_usr (clk_usr),
    .rst_n   (rst_n),
    .adv     (adv_s),
    .word    (carry_word)
  );

  initial clk_usr = 1'b0;
  always #5 clk_usr = ~clk_usr;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] word_of(input int k);
    return EXP_INIT + EXP_INC * 128'(unsigned'(k));
  endfunction

  function automatic logic pick_ready(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One complete run: start, random ready, optional stop after stop_word accepts.
  task automatic apply_stimulus(input int blen, input int glen, input int rdy_pct,
                                input int stop_word, input string tag);
    int   words;
    int   low_run;
    bit   counting;
    bit   stop_pend;
    bit   stop_sent;
    bit   acc;
    bit   end_now;
    bit   fin;
    words = 0; low_run = 0; counting = 0; stop_pend = 0; stop_sent = 0; fin = 0;
    burst_len      = LEN_W'(blen);
    gap_len        = GAP_W'(glen);
    start          = 1'b1;
    tx_if.tx_ready = pick_ready(rdy_pct);
    @(negedge clk_usr);
    start = 1'b0;
    check_bit({tag, " valid_rise"}, tx_if.tx_valid, 1'b1);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (counting) begin
        if (!tx_if.tx_valid) begin
          low_run++;
        end else begin
          check_output({tag, " gap_cycles"}, 128'(unsigned'(low_run)), 128'(unsigned'(glen)));
          counting = 0;
        end
      end
      if (tx_if.tx_valid) begin
        check_output({tag, " data"}, tx_if.tx_data, word_of(n_acc));
      end
      check_bit({tag, " busy"}, busy, 1'b1);
      stop = (!stop_sent && words == stop_word);
      if (stop) stop_sent = 1;
      tx_if.tx_ready = pick_ready(rdy_pct);
      acc = tx_if.tx_valid && tx_if.tx_ready;
      if (acc) end_now = (blen != 0 && words + 1 == blen) || stop_pend || stop;
      else     end_now = !tx_if.tx_valid && stop;
      if (stop) stop_pend = 1;
      @(negedge clk_usr);
      stop = 1'b0;
      if (acc) begin
        n_acc++;
        words++;
        counting = !end_now;
        low_run  = 0;
      end
      check_bit({tag, " done"}, done, end_now);
      if (end_now) begin
        check_bit({tag, " end_valid"}, tx_if.tx_valid, 1'b0);
        check_bit({tag, " end_busy"}, busy, 1'b0);
        fin = 1;
      end
    end
    check_bit({tag, " finished_in_budget"}, fin, 1'b1);
    @(negedge clk_usr);
    check_bit({tag, " done_one_cycle"}, done, 1'b0);
    check_output({tag, " word_cnt"}, 128'(word_cnt), 128'(unsigned'(n_acc)));
  endtask

  initial begin
`ifdef PATGEN_ERR_INJ_EN
    flip_exp = 1'b1;
`else
    flip_exp = 1'b0;
`endif
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; inj_err = 1'b0; adv_s = 1'b0;
    burst_len = '0; gap_len = '0; tx_if.tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk_usr);
    $display("[TB] reset checks");
    check_bit("rst valid", tx_if.tx_valid, 1'b0);
    check_bit("rst busy", busy, 1'b0);
    check_bit("rst done", done, 1'b0);
    check_output("rst word_cnt", 128'(word_cnt), 128'd0);
    check_output("rst tx_data", tx_if.tx_data, EXP_INIT);
    rst_n = 1'b1;
    @(negedge clk_usr);

    // Lane carry through the full-width add
    check_output("carry init", carry_word, CARRY_INIT);
    adv_s = 1'b1;
    @(negedge clk_usr);
    adv_s = 1'b0;
    check_output("carry step", carry_word, CARRY_INIT + EXP_INC);
    check_output("carry lane1", carry_word, CARRY_NEXT);

    // start and stop together must leave the block idle
    start = 1'b1; stop = 1'b1;
    @(negedge clk_usr);
    start = 1'b0; stop = 1'b0;
    check_bit("start_stop busy", busy, 1'b0);
    check_bit("start_stop valid", tx_if.tx_valid, 1'b0);

    $display("[TB] directed bursts");
    apply_stimulus(3, 0, 100, -1, "burst3");
    apply_stimulus(1, 0, 100, -1, "burst1_no_rewind");
    apply_stimulus(2, 2, 100, -1, "burst2_gap2");

    // Backpressure for five cycles with stop raised while the word waits
    burst_len = '0; gap_len = '0; tx_if.tx_ready = 1'b0; start = 1'b1;
    @(negedge clk_usr);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_bit("hold valid", tx_if.tx_valid, 1'b1);
      check_output("hold data", tx_if.tx_data, word_of(n_acc));
      stop  = (i == 2);
      start = (i == 1);
      @(negedge clk_usr);
    end
    stop = 1'b0; start = 1'b0; tx_if.tx_ready = 1'b1;
    check_output("hold data last", tx_if.tx_data, word_of(n_acc));
    @(negedge clk_usr);
    n_acc++;
    check_bit("hold done", done, 1'b1);
    check_bit("hold end valid", tx_if.tx_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_usr);
      check_bit("hold no more words", tx_if.tx_valid, 1'b0);
      check_bit("hold idle busy", busy, 1'b0);
    end
    check_output("hold word_cnt", 128'(word_cnt), 128'(unsigned'(n_acc)));

    // Error injection on the second word of a continuous run
    burst_len = '0; gap_len = '0; tx_if.tx_ready = 1'b1; start = 1'b1;
    @(negedge clk_usr);
    start = 1'b0;
    check_output("inj word1", tx_if.tx_data, word_of(n_acc));
    inj_err = 1'b1;
    @(negedge clk_usr);
    inj_err = 1'b0;
    n_acc++;
    check_output("inj word2", tx_if.tx_data, word_of(n_acc) ^ {127'd0, flip_exp});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_usr);
      n_acc++;
      check_output("inj later word", tx_if.tx_data, word_of(n_acc));
    end
    stop = 1'b1;
    @(negedge clk_usr);
    stop = 1'b0;
    n_acc++;
    check_bit("inj done", done, 1'b1);
    check_output("inj word_cnt", 128'(word_cnt), 128'(unsigned'(n_acc)));

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      int blen, glen, rdy, sw;
      blen = int'($urandom_range(5));
      glen = int'($urandom_range(3));
      rdy  = int'($urandom_range(100, 40));
      if (blen == 0) sw = int'($urandom_range(4));
      else           sw = int'($urandom_range(blen)) - 1;
      apply_stimulus(blen, glen, rdy, sw, "random");
    end

    // Reset in the middle of a continuous run
    burst_len = '0; gap_len = '0; tx_if.tx_ready = 1'b1; start = 1'b1;
    @(negedge clk_usr);
    start = 1'b0;
    repeat (2) @(negedge clk_usr);
    #2 rst_n = 1'b0;
    #1;
    check_bit("midrst valid", tx_if.tx_valid, 1'b0);
    check_bit("midrst busy", busy, 1'b0);
    check_output("midrst word_cnt", 128'(word_cnt), 128'd0);
    check_output("midrst tx_data", tx_if.tx_data, EXP_INIT);
    @(negedge clk_usr);
    rst_n = 1'b1;
    n_acc = 0;
    @(negedge clk_usr);
    apply_stimulus(1, 0, 100, -1, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
